// File: rtl/led_pkg.sv
// Shared types and constants for the RGB LED cross-fader.
package led_pkg;

    typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} led_fade_state_e;

    // Bit order is {r, g, b}.
    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_OFF = 3'b000;

endpackage

// File: rtl/led_step_tick.sv
// Fade-step prescaler: tick is high for one cycle every STEP_DIV cycles; clr restarts the count.
module led_step_tick #(
    parameter int STEP_DIV = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/led_rgb_fader.sv
// PWM RGB LED driver that cross-fades (out, swap, in) on every colour change.
// Optional LED_GAMMA_EN selects square-law brightness; default build is linear.
module led_rgb_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                r_in,
    input  logic                g_in,
    input  logic                b_in,
    input  logic [PWM_BITS-1:0] duty_max,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1);

    led_fade_state_e     state;
    rgb_t                sync_meta;
    rgb_t                req_rgb;
    rgb_t                cur_rgb;
    logic [PWM_BITS-1:0] lvl;
    logic [PWM_BITS-1:0] eff_lvl;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                leave;

    // The colour request is asynchronous and may glitch; two flops settle it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= RGB_OFF;
            req_rgb   <= RGB_OFF;
        end else begin
            sync_meta <= {r_in, g_in, b_in};
            req_rgb   <= sync_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + LVL_ONE;
        end
    end

    // High in any cycle where the FSM will change state, so each state's step timing starts fresh.
    // NOTE: leave gets a default before the case so no latch is inferred.
    always_comb begin
        leave = 1'b0;
        unique case (state)
            IDLE:     leave = (req_rgb != cur_rgb);
            FADE_OUT: leave = (lvl == '0);
            SWAP:     leave = 1'b1;
            FADE_IN:  leave = (req_rgb != cur_rgb) || (lvl >= duty_max);
            default:  leave = 1'b1;
        endcase
    end

    led_step_tick #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (leave),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lvl     <= '0;
            cur_rgb <= RGB_OFF;
        end else begin
            unique case (state)
                IDLE: begin
                    lvl <= duty_max;
                    if (req_rgb != cur_rgb) state <= FADE_OUT;
                end
                FADE_OUT: begin
                    if (lvl == '0)  state <= SWAP;
                    else if (tick)  lvl   <= lvl - LVL_ONE;
                end
                SWAP: begin
                    cur_rgb <= req_rgb;
                    state   <= FADE_IN;
                end
                FADE_IN: begin
                    // A new request mid fade-in reverses from the current level.
                    if (req_rgb != cur_rgb) begin
                        state <= FADE_OUT;
                    end else if (lvl >= duty_max) begin
                        lvl   <= duty_max;
                        state <= IDLE;
                    end else if (tick) begin
                        lvl <= lvl + LVL_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] lvl_sq;
    assign lvl_sq  = lvl * lvl;
    assign eff_lvl = lvl_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign eff_lvl = lvl;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= cur_rgb[2] && (pwm_cnt < eff_lvl);
            led_g <= cur_rgb[1] && (pwm_cnt < eff_lvl);
            led_b <= cur_rgb[0] && (pwm_cnt < eff_lvl);
        end
    end

    assign busy = (state != IDLE);

endmodule
